// File: rtl/systolic_sequencer.sv
// Sequencer for an MxN weight-stationary systolic array: loads weight columns,
// skews activation vectors into the array and deskews the column psums back.
//
// state  | meaning
// IDLE   | waiting for start
// LOAD_W | accepting N weight columns, plus one settle cycle after the last strobe
// STREAM | accepting activation vectors, one wavefront slot per cycle
// DRAIN  | counting down until the last result has left the array
// DONE   | one-cycle done pulse
module systolic_sequencer #(
  parameter int M          = 2,
  parameter int N          = 2,
  parameter int ARRAY_LAT  = 3,
  parameter int CNT_W      = 16,
  parameter int A_WIDTH    = 8,
  parameter int B_WIDTH    = 8,
  parameter int C_WIDTH    = 32,
  parameter int CTRL_WIDTH = 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  input  logic [CNT_W-1:0]                       num_vec,
  output logic                                   busy,
  output logic                                   done,
  input  logic                                   w_valid,
  output logic                                   w_ready,
  input  logic [M-1:0][A_WIDTH-1:0]              w_data,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [M-1:0][B_WIDTH-1:0]              in_data,
  output logic [CTRL_WIDTH-1:0]                  ctrl,
  output logic [M-1:0][B_WIDTH-1:0]              iact,
  output logic [N-1:0][M-1:0][CTRL_WIDTH-1:0]    wctrl,
  output logic [N-1:0][M-1:0][A_WIDTH-1:0]       weights,
  input  logic [N-1:0][C_WIDTH-1:0]              psum,
  output logic                                   out_valid,
  output logic [N-1:0][C_WIDTH-1:0]              out_data
);

  localparam int COL_W      = $clog2(N + 1);
  localparam int DRAIN_INIT = ARRAY_LAT + N + M;
  localparam int DR_W       = $clog2(DRAIN_INIT + 1);
  localparam int VLD_LEN    = ARRAY_LAT + N;

  typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, DRAIN, DONE} state_t;

  state_t             state, state_nx;
  logic [CNT_W-1:0]   vec_left;
  logic [COL_W-1:0]   col;
  logic [DR_W-1:0]    drain_cnt;
  logic               cols_loaded;
  logic               w_fire;
  logic               in_fire;

  assign cols_loaded = (col == COL_W'(N));
  assign w_fire      = w_valid && w_ready;
  assign in_fire     = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // The settle cycle in LOAD_W keeps in_ready low while the last wctrl strobe is out.
  always_comb begin
    state_nx = state;
    busy     = 1'b1;
    done     = 1'b0;
    w_ready  = 1'b0;
    in_ready = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nx = LOAD_W;
      end
      LOAD_W: begin
        w_ready = !cols_loaded;
        if (cols_loaded) state_nx = (vec_left == '0) ? DRAIN : STREAM;
      end
      STREAM: begin
        in_ready = 1'b1;
        if (in_fire && vec_left == CNT_W'(1)) state_nx = DRAIN;
      end
      DRAIN: begin
        if (drain_cnt == '0) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      vec_left  <= '0;
      col       <= '0;
      drain_cnt <= '0;
    end else begin
      if (state == IDLE && start) begin
        vec_left <= num_vec;
        col      <= '0;
      end
      if (w_fire)  col      <= col + COL_W'(1);
      if (in_fire) vec_left <= vec_left - CNT_W'(1);
      if (state != DRAIN && state_nx == DRAIN)
        drain_cnt <= DR_W'(DRAIN_INIT);
      else if (state == DRAIN && drain_cnt != '0)
        drain_cnt <= drain_cnt - DR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wctrl   <= '0;
      weights <= '0;
    end else begin
      wctrl <= '0;
      for (int j = 0; j < N; j++) begin
        if (w_fire && col == COL_W'(j)) begin
          for (int i = 0; i < M; i++) begin
            wctrl[j][i]   <= CTRL_WIDTH'(1);
            weights[j][i] <= w_data[i];
          end
        end
      end
    end
  end

  // Slot register: every cycle launches either a real vector or an all-zero bubble.
  logic [M-1:0][B_WIDTH-1:0] slot;

  always_ff @(posedge clk) begin
    if (!rst) begin
      ctrl <= '0;
      slot <= '0;
    end else begin
      ctrl <= CTRL_WIDTH'(in_fire);
      slot <= in_fire ? in_data : '0;
    end
  end

  for (genvar i = 0; i < M; i++) begin : g_skew
    if (i == 0) begin : g_direct
      assign iact[0] = slot[0];
    end else begin : g_sr
      logic [B_WIDTH-1:0] sr [i];
      always_ff @(posedge clk) begin
        if (!rst) begin
          for (int k = 0; k < i; k++) sr[k] <= '0;
        end else begin
          sr[0] <= slot[i];
          for (int k = 1; k < i; k++) sr[k] <= sr[k-1];
        end
      end
      assign iact[i] = sr[i-1];
    end
  end

  // Later columns arrive later, so column j waits N-1-j cycles to line up with column N-1.
  logic [N-1:0][C_WIDTH-1:0] aligned;

  for (genvar j = 0; j < N; j++) begin : g_deskew
    if (N - 1 - j == 0) begin : g_direct
      assign aligned[j] = psum[j];
    end else begin : g_dl
      logic [C_WIDTH-1:0] dl [N-1-j];
      always_ff @(posedge clk) begin
        if (!rst) begin
          for (int k = 0; k < N - 1 - j; k++) dl[k] <= '0;
        end else begin
          dl[0] <= psum[j];
          for (int k = 1; k < N - 1 - j; k++) dl[k] <= dl[k-1];
        end
      end
      assign aligned[j] = dl[N-2-j];
    end
  end

  logic [VLD_LEN-1:0] vld;

  always_ff @(posedge clk) begin
    if (!rst) begin
      vld      <= '0;
      out_data <= '0;
    end else begin
      vld      <= {vld[VLD_LEN-2:0], |ctrl};
      out_data <= aligned;
    end
  end

  assign out_valid = vld[VLD_LEN-1];

endmodule

// File: tb/tb_systolic_sequencer.sv
// Bench for systolic_sequencer: a behavioural array model feeds psum from the
// skewed iact stream; a scoreboard checks aligned results against dot products.
module tb_systolic_sequencer;
  localparam int M = 2, N = 2, LAT = 3, CNT_W = 16;
  localparam int AW = 8, BW = 8, CW = 32, CTW = 1;
  localparam int WDW = M * AW, IDW = M * BW, WW = N * M * AW;
  localparam int HIST = 1024;

  logic clk = 0, rst = 0, start = 0;
  logic [CNT_W-1:0] num_vec = '0;
  logic busy, done, w_ready, in_ready, out_valid;
  logic w_valid = 0, in_valid = 0;
  logic [M-1:0][AW-1:0] w_data = '0;
  logic [M-1:0][BW-1:0] in_data = '0;
  logic [CTW-1:0] ctrl;
  logic [M-1:0][BW-1:0] iact;
  logic [N-1:0][M-1:0][CTW-1:0] wctrl;
  logic [N-1:0][M-1:0][AW-1:0] weights;
  logic [N-1:0][CW-1:0] psum = '0;
  logic [N-1:0][CW-1:0] out_data;

  systolic_sequencer #(.M(M), .N(N), .ARRAY_LAT(LAT), .CNT_W(CNT_W), .A_WIDTH(AW),
                       .B_WIDTH(BW), .C_WIDTH(CW), .CTRL_WIDTH(CTW)) dut (
    .clk(clk), .rst(rst), .start(start), .num_vec(num_vec), .busy(busy), .done(done),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .ctrl(ctrl), .iact(iact), .wctrl(wctrl), .weights(weights), .psum(psum),
    .out_valid(out_valid), .out_data(out_data));

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0][CW-1:0] data;
    int                   cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t e_push, e_pop;
  int n_cmp = 0, n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [N-1:0][M-1:0][AW-1:0] wexp = '0, warr = '0, last_w = '0;
  logic [N-1:0][M-1:0][CTW-1:0] wc_exp;
  logic [BW-1:0] hist [M][HIST];
  logic [CW-1:0] s_arr, s_exp;
  int k_arr;
  int exp_col = 0, n_strobe = 0, last_strobe = 0, first_ready = -1, ready_cnt = 0;
  int n_acc = 0, done_cnt = 0, done_cyc = -1, ov_cnt = 0;
  bit acc_prev = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_ctl"}, 64'({ctrl, iact, wctrl, out_valid, busy, done, w_ready, in_ready}), 64'(0));
    check({tag, "_weights"}, 64'(weights), 64'(0));
    check({tag, "_out_data"}, 64'(out_data), 64'(0));
  endtask

  // Array model, handshake tracking and expected-result generation.
  always @(negedge clk) begin
    for (int j = 0; j < N; j++)
      for (int i = 0; i < M; i++)
        if (wctrl[j][i][0]) warr[j][i] = weights[j][i];
    for (int i = 0; i < M; i++) hist[i][cyc % HIST] = iact[i];
    for (int j = 0; j < N; j++) begin
      s_arr = '0;
      for (int i = 0; i < M; i++) begin
        k_arr = cyc - LAT - j + i;
        if (k_arr >= 0) s_arr = s_arr + CW'(warr[j][i]) * CW'(hist[i][k_arr % HIST]);
      end
      psum[j] = s_arr;
    end

    check("ctrl_slot", 64'(ctrl), 64'(acc_prev));
    acc_prev = rst && in_valid && in_ready;
    if (rst && in_valid && in_ready) begin
      for (int j = 0; j < N; j++) begin
        s_exp = '0;
        for (int i = 0; i < M; i++) s_exp = s_exp + CW'(wexp[j][i]) * CW'(in_data[i]);
        e_push.data[j] = s_exp;
      end
      e_push.cyc = cyc + 1 + LAT + N;
      exp_q.push_back(e_push);
      n_acc++;
    end
    if (rst && in_ready) begin
      ready_cnt++;
      if (first_ready < 0) first_ready = cyc;
    end

    if (wctrl != '0) begin
      n_strobe++;
      last_strobe = cyc;
      if (exp_col >= N) check("extra_strobe", 64'(n_strobe), 64'(N));
      else begin
        wc_exp = '0;
        for (int i = 0; i < M; i++) wc_exp[exp_col][i] = CTW'(1);
        check("wctrl_col", 64'(wctrl), 64'(wc_exp));
        check("weights_col", 64'(weights[exp_col]), 64'(wexp[exp_col]));
        exp_col++;
      end
      last_w = weights;
    end else if (rst) begin
      check("weights_hold", 64'(weights), 64'(last_w));
    end
    if (!rst) last_w = '0;

    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (out_valid) begin
      ov_cnt++;
      if (exp_q.size() == 0) check("unexpected_out_valid", 64'(out_valid), 64'(0));
      else begin
        e_pop = exp_q.pop_front();
        check("out_data", 64'(out_data), 64'(e_pop.data));
        check("out_cycle", 64'(cyc), 64'(e_pop.cyc));
      end
    end
  end

  // mode: 0 = back-to-back, 1 = alternate valid, 2 = random valid
  task automatic run_job(input int nv, input int wgap, input int mode, input int rst_at, input bit busy_start);
    int k, guard, ov0;
    bit seen;
    exp_col = 0; n_strobe = 0; first_ready = -1; ready_cnt = 0;
    n_acc = 0; done_cnt = 0; done_cyc = -1;
    @(posedge clk); #1;
    start = 1; num_vec = CNT_W'(nv);
    @(posedge clk); #1;
    start = 0; num_vec = CNT_W'($urandom);
    for (int j = 0; j < N; j++) begin
      for (int g = 0; g < wgap; g++) begin
        w_valid = 0; w_data = WDW'($urandom);
        @(posedge clk); #1;
      end
      w_valid = 1; w_data = wexp[j];
      guard = 0;
      while (!w_ready && guard < 20) begin
        @(posedge clk); #1;
        guard++;
      end
      if (guard >= 20) check("w_ready_timeout", 64'(w_ready), 64'(1));
      @(posedge clk); #1;
      w_valid = 0;
    end

    k = 0; guard = 0; seen = 0;
    while (!seen && guard < 400) begin
      start = busy_start && guard == 4;
      if (start) num_vec = CNT_W'(7);
      if (rst_at > 0 && n_acc >= rst_at && in_ready) begin
        in_valid = 0; rst = 0;
        @(posedge clk); #1;
        rst = 1;
        exp_q.delete();
        check_zero("after_reset");
        ov0 = ov_cnt;
        repeat (20) @(posedge clk);
        #1;
        check("no_out_after_reset", 64'(ov_cnt - ov0), 64'(0));
        check("no_done_after_reset", 64'(done_cnt), 64'(0));
        return;
      end
      if (in_ready) begin
        case (mode)
          0:       in_valid = 1;
          1:       in_valid = (k % 2 == 0);
          default: in_valid = 1'($urandom_range(0, 1));
        endcase
        k++;
      end else begin
        in_valid = 1'($urandom_range(0, 1));
      end
      in_data = IDW'($urandom);
      @(posedge clk); #1;
      guard++;
      seen = done;
    end
    start = 0;
    in_valid = 0;
    if (!seen) check("done_timeout", 64'(done), 64'(1));
    @(posedge clk); #1;
    check("queue_empty_at_done", 64'(exp_q.size()), 64'(0));
    check("busy_after_done", 64'(busy), 64'(0));
    check("done_pulses", 64'(done_cnt), 64'(1));
    check("vectors_accepted", 64'(n_acc), 64'(nv));
    check("weight_strobes", 64'(n_strobe), 64'(N));
    if (nv == 0) begin
      check("no_in_ready", 64'(ready_cnt), 64'(0));
      check("done_latency", 64'(done_cyc - (last_strobe + 1)), 64'(LAT + N + M + 1));
    end else begin
      check("first_in_ready", 64'(first_ready), 64'(last_strobe + 1));
    end
    if (busy_start) begin
      repeat (3) @(posedge clk);
      #1;
      check("idle_after_ignored_start", 64'(busy), 64'(0));
    end
  endtask

  initial begin
    rst = 0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset_state");
    rst = 1;

    for (int j = 0; j < N; j++)
      for (int i = 0; i < M; i++) wexp[j][i] = AW'(j * M + i + 1);
    run_job(4, 0, 0, 0, 0);
    wexp = WW'($urandom); run_job(2, 0, 1, 0, 0);
    wexp = WW'($urandom); run_job(0, 0, 0, 0, 0);
    wexp = WW'($urandom); run_job(3, 3, 2, 0, 0);
    wexp = WW'($urandom); run_job(10, 0, 0, 3, 0);
    wexp = WW'($urandom); run_job(5, 1, 2, 0, 0);
    wexp = WW'($urandom); run_job(6, 0, 0, 0, 1);
    for (int r = 0; r < 4; r++) begin
      wexp = WW'($urandom);
      run_job(int'($urandom_range(1, 8)), int'($urandom_range(0, 2)), 2, 0, 0);
    end
    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (compared %0d)", n_cmp);
    $fatal(1);
  end

endmodule

// File: doc/systolic_sequencer.md
# systolic_sequencer

Sequencing controller for the M×N weight-stationary systolic array (`systolic`).
- Per job: loads one column of weights per beat into the array, then accepts unskewed activation vectors and issues them as a row-skewed wavefront stream.
- Captures the column psums and deskews them back into aligned N-wide result vectors.
- Sits between the buffer/DMA side (valid/ready streams) and the array's `ctrl`, `iact`, `wctrl`, `weights` and `psum` ports.

## Interface
Parameters:
- `M`, 2: array rows (activation lanes).
- `N`, 2: array columns (psum lanes).
- `ARRAY_LAT`, 3: cycles from `ctrl`/`iact` row 0 driven to column 0 psum visible on `psum[0]`. Column j is visible `ARRAY_LAT + j` cycles after that drive.
- `CNT_W`, 16: width of the vector counter.

Ports (widths use the codebase `A_WIDTH`/`B_WIDTH`/`C_WIDTH`/`CTRL_WIDTH` macros):
- `clk` in 1: single clock, all logic on the rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `start` in 1: begin a job; sampled only in IDLE.
- `num_vec` in CNT_W: number of activation vectors in the job; sampled with `start`.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at job end.
- `w_valid` / `w_ready` in / out 1: weight column handshake.
- `w_data` in A_WIDTH×M: weights for the current column; lane i goes to row i.
- `in_valid` / `in_ready` in / out 1: activation handshake.
- `in_data` in B_WIDTH×M: one unskewed activation vector.
- `ctrl` out CTRL_WIDTH: to the array; 1 = valid wavefront slot, 0 = bubble.
- `iact` out B_WIDTH×M: skewed activations to the array.
- `wctrl` out CTRL_WIDTH×N×M: per-PE weight-load strobe, `[j][i]`.
- `weights` out A_WIDTH×N×M: per-PE weight value, `[j][i]`.
- `psum` in C_WIDTH×N: bottom drain of the array.
- `out_valid` out 1: aligned result valid. There is no ready; the array cannot stall.
- `out_data` out C_WIDTH×N: aligned result vector.

## Operation
- **FSM states:** IDLE, LOAD_W, STREAM, DRAIN, DONE.
- **IDLE:**
  - `start`=1 latches `num_vec` into `vec_left` and clears `col`; go to LOAD_W.
  - `start` is ignored in every other state.
- **LOAD_W:**
  - `w_ready`=1.
  - On `w_valid&&w_ready`: `wctrl[col][i]`=1 and `weights[col][i]`=`w_data[i]` for all i, for exactly the next cycle. `col` then increments.
  - `weights` values hold after the strobe; `wctrl` returns to 0.
  - After beat N-1: go to STREAM, or to DRAIN if `vec_left`==0.
- **STREAM:**
  - `in_ready`=1.
  - Each accepted vector drives a slot: `ctrl`=1 and `iact[i]`=`in_data[i]` delayed by i extra cycles.
  - Each cycle without acceptance is a bubble: `ctrl`=0 and row-0 `iact`=0, propagated through the skew.
  - `vec_left` decrements per accept. When the last vector is accepted, go to DRAIN.
- **DRAIN:**
  - `in_ready`=0.
  - A drain counter loads `ARRAY_LAT+N+M`. Go to DONE at 0.
- **DONE:** `done`=1 for one cycle, then IDLE.
- **Skew:** row i uses an i-stage shift register (row 0 has none). `ctrl` is driven unskewed, because the array broadcasts it as a wavefront internally.
- **Deskew:**
  - Column j psum is delayed by N-1-j stages.
  - A valid bit travels through a shift register of `ARRAY_LAT+N` stages tagged from the `ctrl`=1 slot.
  - `out_valid` asserts only for real slots; bubbles produce no output.
- **Arithmetic:** psums are passed through unmodified at C_WIDTH. `num_vec` is unsigned; no wrap within a job.

## Timing
- **Accept to row 0:** vector accepted at cycle t drives `ctrl`=1 and `iact[0]` at t+1; `iact[i]` at t+1+i.
- **Psum arrival:** column j psum for that vector is at `psum[j]` at t+1+ARRAY_LAT+j.
- **Result output:** `out_valid`/`out_data` at t+1+ARRAY_LAT+N (registered). All N lanes belong to the same vector.
- **Throughput:** one vector per cycle with no gaps.
- **Weight strobe:** weight beat accepted at cycle t produces `wctrl`/`weights` at t+1.
- **First activation:** the first `in_ready` is the cycle after the last weight strobe. This guarantees the weights are latched before the first activation.
- **Drain coverage:** the final `out_valid` occurs no later than the cycle `done` pulses.
- **Reset** (`rst`=0 at an edge, any state):
  - FSM goes to IDLE.
  - All skew, deskew and valid pipelines are cleared.
  - Outputs go to 0: `ctrl`, `iact`, `wctrl`, `weights`, `out_valid`, `out_data`, `busy`, `done`, `w_ready`, `in_ready`.
  - In-flight results are discarded and no `out_valid` follows.

## Test plan
- **Basic job, M=N=2, ARRAY_LAT=3:** weights [[1,2],[3,4]], 4 back-to-back vectors → `out_valid` at t+6 after each accept, four consecutive aligned results, `done` once, `busy` low after.
- **Bubbles:** `in_valid` toggles 1,0,1,0 with 2 vectors → `ctrl` pattern 1,0,1; exactly 2 `out_valid` pulses 2 cycles apart.
- **No vectors:** `num_vec`=0 → N `wctrl` strobes, no `in_ready`, no `out_valid`, then `done` after ARRAY_LAT+N+M+1 cycles.
- **Weight stalls:** `w_valid` gaps of 3 cycles → strobes only on handshakes, column order 0..N-1, `weights` held between strobes.
- **Mid-stream reset:** `rst`=0 during STREAM → all outputs 0 next cycle; no `out_valid` afterward; new `start` works normally.
- **Start while busy:** `start` pulsed in STREAM → ignored, `num_vec` unchanged, job completes as programmed.
